serial_add_arb: RTL and testbench
=================================

# serial_add_arb

Two-requester bit-serial adder controller. It arbitrates round-robin between two clients and captures the winner's operands. It then sequences a single one-bit full-adder cell, built from two `half_adder` instances, over `WIDTH` cycles and returns a registered sum, carry-out and completion pulse. It sits between client logic and the shared one-bit adder datapath, so no client needs its own parallel adder.

## Interface
Parameters:
- `WIDTH`, default 8: operand and sum width in bits, minimum 2.

Ports:
- `CLK`, input, 1: single clock; all state changes on the rising edge.
- `RST_N`, input, 1: asynchronous, active-low reset.
- `REQ0`, input, 1: requester 0 request (level).
- `A0`, `B0`, input, `WIDTH`: requester 0 operands.
- `REQ1`, input, 1: requester 1 request (level).
- `A1`, `B1`, input, `WIDTH`: requester 1 operands.
- `GNT0`, `GNT1`, output, 1: grant, one-hot, held from capture through the DONE cycle.
- `BUSY`, output, 1: high in RUN and DONE.
- `DONE`, output, 1: one-cycle completion pulse.
- `DONE_ID`, output, 1: requester served by the latest completion.
- `SUM`, output, `WIDTH`: result of the latest completion, held.
- `COUT`, output, 1: carry-out of the latest completion, held.
- `OVF`, output, 1: signed overflow of the latest completion; present only with `SERIAL_ADD_OVF_EN`.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - Requests are sampled only in IDLE.
  - If any `REQx` is high at the edge, the winner's A/B are loaded into shift registers, the carry flop and bit counter are cleared, `GNTx` is set and the FSM goes to RUN.
- **Arbitration**
  - A single request wins outright.
  - If both are high, the requester not served last wins.
  - The last-served pointer resets to 1, so requester 0 wins the first tie.
  - The pointer updates at capture.
- **RUN**
  - Each cycle the full-adder cell adds the shift-register LSBs and the carry flop.
  - The sum bit enters the internal sum shift register at its MSB, shifting right.
  - The carry flop takes the cell's carry-out.
  - The operand registers shift right and the counter increments.
  - When the counter reaches `WIDTH-1`, the FSM goes to DONE.
  - The final edge also loads `SUM`, `COUT`, `DONE_ID` and `OVF`.
- **DONE**
  - `DONE` is 1 for exactly one cycle and the grant is still held.
  - The next state is IDLE unconditionally.
  - A requester must drop `REQx` in the DONE cycle. A REQ still high in the following IDLE cycle is a new transaction.
- **Output behaviour**
  - Operand inputs are don't-care except at the capture edge.
  - `SUM` and `COUT` change only on the edge entering DONE and never show partial results.
- **Arithmetic**
  - Unsigned result: `{COUT,SUM} = A + B`, modulo 2^(WIDTH+1).
  - `OVF` is the carry into the MSB XOR `COUT`.
- **Reset**
  - Reset at any time, including mid-RUN, aborts the transaction with no DONE.
  - All flops clear, the FSM returns to IDLE and the pointer returns to 1.

## Timing
- Reset values:
  - `GNT0`, `GNT1`, `BUSY`, `DONE`, `DONE_ID`, `COUT`, `OVF` are 0.
  - `SUM` is 0.
  - FSM is in IDLE.
- Latency, with REQ high in IDLE at edge t:
  - `GNT` and `BUSY` rise after edge t.
  - RUN occupies cycles t+1 … t+`WIDTH`.
  - `DONE` is high in cycle t+`WIDTH`+1.
  - IDLE resumes at t+`WIDTH`+2.
- Throughput: one addition per `WIDTH`+2 cycles under continuous requests.
- A request arriving during RUN or DONE waits. It is not lost while REQ is held.

## Configuration
- `SERIAL_ADD_OVF_EN` defined:
  - The `OVF` port and the carry-into-MSB capture flop exist.
  - `OVF` updates together with `SUM`.
- Not defined:
  - No `OVF` port and no overflow logic.
  - All other behaviour is identical.

## Structure
- Package `serial_add_pkg` holds:
  - the state encoding (IDLE, RUN, DONE);
  - requester ID constants `REQ_ID0`/`REQ_ID1`;
  - the counter width function `$clog2(WIDTH)`.
- Sub-module `serial_fa_cell`: two `half_adder` instances plus an OR for carry. It is purely combinational and instantiated once.
- FSM, arbiter, shift registers and output registers live in the top module.

## Test plan
All scenarios use `WIDTH`=8.
- **Single request:** REQ0, A0=0x3C, B0=0x5A → GNT0 after 1 edge; DONE at cycle 9 with SUM=0x96, COUT=0, DONE_ID=0.
- **Carry ripple:** REQ1, A1=0xFF, B1=0x01 → SUM=0x00, COUT=1, DONE_ID=1; `SUM` holds its previous value throughout RUN.
- **Tie and fairness:** REQ0 and REQ1 both high and held, A0+B0=0x10+0x01, A1+B1=0x20+0x02 → grants in order 0, 1, 0; SUM 0x11, 0x22, 0x11; DONE pulses 10 cycles apart; never both grants high.
- **Reset mid-operation:** assert RST_N=0 at RUN cycle 4 → all outputs 0 immediately; no DONE; after release, a tie grants requester 0.
- **Overflow** (`SERIAL_ADD_OVF_EN` defined): 0x7F+0x01 → SUM=0x80, COUT=0, OVF=1. Then 0x80+0x80 → SUM=0x00, COUT=1, OVF=1. Then 0xFF+0x01 → OVF=0.
- **REQ held through DONE:** REQ0 held high through DONE → a second transaction is captured in the cycle after DONE, with the same result repeated.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial_add_arb bit-serial adder controller.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic REQ_ID0 = 1'b0;
    localparam logic REQ_ID1 = 1'b1;

    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/half_adder.sv
// One-bit half adder, building block of the serial full-adder cell.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_fa_cell.sv
// Combinational one-bit full adder made from two half adders and an OR for carry.
module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (.a(a),  .b(b),   .s(s1),  .c(c1));
    half_adder u_ha1 (.a(s1), .b(cin), .s(sum), .c(c2));

    assign cout = c1 | c2;

endmodule

// File: rtl/serial_add_arb.sv
// Two-requester round-robin arbiter driving a shared bit-serial adder over WIDTH cycles.
// Define SERIAL_ADD_OVF_EN to add the signed-overflow output OVF.
module serial_add_arb
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REQ0,
    input  logic [WIDTH-1:0] A0,
    input  logic [WIDTH-1:0] B0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] A1,
    input  logic [WIDTH-1:0] B1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             BUSY,
    output logic             DONE,
    output logic             DONE_ID,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             last_q, last_d;
    logic             done_id_q, done_id_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic win_id;
    logic last_bit;
    logic fa_sum;
    logic fa_cout;

    serial_fa_cell u_fa (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .cin  (c_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Requester 1 wins alone, or on a tie when requester 0 was served last.
    assign win_id   = REQ1 & (~REQ0 | (last_q == REQ_ID0));
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (REQ0 | REQ1) state_d = ST_RUN;
            ST_RUN:  if (last_bit)    state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        gnt0_d    = gnt0_q;
        gnt1_d    = gnt1_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        last_d    = last_q;
        done_id_d = done_id_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (REQ0 | REQ1) begin
                    a_d    = win_id ? A1 : A0;
                    b_d    = win_id ? B1 : B0;
                    c_d    = 1'b0;
                    cnt_d  = '0;
                    gnt0_d = ~win_id;
                    gnt1_d = win_id;
                    busy_d = 1'b1;
                    last_d = win_id;
                end
            end
            ST_RUN: begin
                s_d   = {fa_sum, s_q[WIDTH-1:1]};
                c_d   = fa_cout;
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                // Final bit: publish the complete result; c_q is the carry into the MSB here.
                if (last_bit) begin
                    sum_d     = {fa_sum, s_q[WIDTH-1:1]};
                    cout_d    = fa_cout;
                    done_id_d = last_q;
                    done_d    = 1'b1;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d     = c_q ^ fa_cout;
`endif
                end
            end
            ST_DONE: begin
                gnt0_d = 1'b0;
                gnt1_d = 1'b0;
                busy_d = 1'b0;
            end
            default: begin
                gnt0_d = 1'b0;
                gnt1_d = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_q       <= '0;
            b_q       <= '0;
            s_q       <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            last_q    <= REQ_ID1;
            done_id_q <= 1'b0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            s_q       <= s_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            last_q    <= last_d;
            done_id_q <= done_id_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign GNT0    = gnt0_q;
    assign GNT1    = gnt1_q;
    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign DONE_ID = done_id_q;
    assign SUM     = sum_q;
    assign COUT    = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign OVF     = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_arb.sv
// Self-checking bench for serial_add_arb (WIDTH=8): vector table, scoreboard, corner sequences.
module tb_serial_add_arb;

    localparam int unsigned W = 8;

    logic         CLK;
    logic         RST_N;
    logic         REQ0, REQ1;
    logic [W-1:0] A0, B0, A1, B1;
    logic         GNT0, GNT1, BUSY, DONE, DONE_ID, COUT;
    logic [W-1:0] SUM;
`ifdef SERIAL_ADD_OVF_EN
    logic         OVF;
`endif

    serial_add_arb #(.WIDTH(W)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .REQ0    (REQ0),
        .A0      (A0),
        .B0      (B0),
        .REQ1    (REQ1),
        .A1      (A1),
        .B1      (B1),
        .GNT0    (GNT0),
        .GNT1    (GNT1),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .DONE_ID (DONE_ID),
        .SUM     (SUM),
        .COUT    (COUT)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .OVF     (OVF)
`endif
    );

    typedef struct {
        logic         id;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    typedef struct {
        logic         id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Completion monitor: every DONE pulse must match the oldest scoreboard entry.
    always @(negedge CLK) begin
        if (RST_N) begin
            check("gnt_onehot", 32'(GNT0 & GNT1), 32'd0);
            if (DONE) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_id", 32'(DONE_ID), 32'(e.id));
                    check("sum", 32'(SUM), 32'(e.sum));
                    check("cout", 32'(COUT), 32'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
                    check("ovf", 32'(OVF), 32'(e.ovf));
`endif
                end
            end
        end
    end

    // One single-requester transaction: grant latency, held SUM during RUN, DONE latency.
    task automatic run_one(input vec_t v);
        logic [W-1:0] held;
        int n;
        sb.push_back('{v.id, v.sum, v.cout, v.ovf});
        if (v.id) begin REQ1 = 1'b1; A1 = v.a; B1 = v.b; end
        else      begin REQ0 = 1'b1; A0 = v.a; B0 = v.b; end
        @(negedge CLK);
        check("gnt_after_capture", 32'({GNT1, GNT0}), v.id ? 32'd2 : 32'd1);
        check("busy_after_capture", 32'(BUSY), 32'd1);
        REQ0 = 1'b0; REQ1 = 1'b0;
        A0 = W'($urandom); B0 = W'($urandom); A1 = W'($urandom); B1 = W'($urandom);
        held = SUM;
        n = 0;
        while (!DONE && n < 20) begin
            @(negedge CLK);
            n++;
            if (!DONE) check("sum_held_in_run", 32'(SUM), 32'(held));
        end
        check("done_latency", 32'(n), 32'd8);
        check("gnt_in_done", 32'({GNT1, GNT0}), v.id ? 32'd2 : 32'd1);
        @(negedge CLK);
        check("idle_busy", 32'(BUSY), 32'd0);
        check("idle_gnt", 32'({GNT1, GNT0}), 32'd0);
    endtask

    // Waits for the next DONE pulse (bounded) and returns the cycle it appeared in.
    task automatic wait_done(output int at);
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!DONE && n < 30);
        if (!DONE) check("done_timeout", 32'd1, 32'd0);
        at = cyc;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
    endtask

    initial begin
        int t0, t1, t2;
        vecs[0] = '{1'b0, 8'h3C, 8'h5A, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[4] = '{1'b0, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};

        RST_N = 1'b0;
        REQ0 = 1'b0; REQ1 = 1'b0;
        A0 = '0; B0 = '0; A1 = '0; B1 = '0;
        repeat (3) @(negedge CLK);
        check("rst_gnt", 32'({GNT1, GNT0}), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_done", 32'(DONE), 32'd0);
        check("rst_done_id", 32'(DONE_ID), 32'd0);
        check("rst_sum", 32'(SUM), 32'd0);
        check("rst_cout", 32'(COUT), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", 32'(OVF), 32'd0);
`endif
        RST_N = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 6; i++) run_one(vecs[i]);

        // Tie with pointer fresh from reset: grants alternate 0,1,0 every 10 cycles.
        do_reset();
        sb.push_back('{1'b0, 8'h11, 1'b0, 1'b0});
        sb.push_back('{1'b1, 8'h22, 1'b0, 1'b0});
        sb.push_back('{1'b0, 8'h11, 1'b0, 1'b0});
        A0 = 8'h10; B0 = 8'h01; A1 = 8'h20; B1 = 8'h02;
        REQ0 = 1'b1; REQ1 = 1'b1;
        wait_done(t0);
        wait_done(t1);
        check("tie_gap1", 32'(t1 - t0), 32'd10);
        wait_done(t2);
        check("tie_gap2", 32'(t2 - t1), 32'd10);
        REQ0 = 1'b0; REQ1 = 1'b0;
        repeat (2) @(negedge CLK);
        check("tie_idle", 32'(BUSY), 32'd0);

        // REQ0 held through DONE: back-to-back identical transaction.
        sb.push_back('{1'b0, 8'h46, 1'b0, 1'b0});
        sb.push_back('{1'b0, 8'h46, 1'b0, 1'b0});
        A0 = 8'h12; B0 = 8'h34; REQ0 = 1'b1;
        wait_done(t0);
        wait_done(t1);
        check("held_gap", 32'(t1 - t0), 32'd10);
        REQ0 = 1'b0;
        repeat (2) @(negedge CLK);
        check("held_idle", 32'(BUSY), 32'd0);
        check("held_sum", 32'(SUM), 32'h46);

        // Reset in RUN cycle 4 aborts without DONE; afterwards a tie goes to requester 0.
        A1 = 8'h0F; B1 = 8'h0F; REQ1 = 1'b1;
        @(negedge CLK);
        check("abort_gnt1", 32'(GNT1), 32'd1);
        REQ1 = 1'b0;
        repeat (3) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check("abort_gnt", 32'({GNT1, GNT0}), 32'd0);
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_done", 32'(DONE), 32'd0);
        check("abort_sum", 32'(SUM), 32'd0);
        check("abort_cout", 32'(COUT), 32'd0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (12) @(negedge CLK);
        check("abort_no_done", 32'(DONE), 32'd0);
        sb.push_back('{1'b0, 8'h03, 1'b0, 1'b0});
        A0 = 8'h01; B0 = 8'h02; A1 = 8'h03; B1 = 8'h04;
        REQ0 = 1'b1; REQ1 = 1'b1;
        @(negedge CLK);
        check("post_reset_tie", 32'({GNT1, GNT0}), 32'd1);
        REQ0 = 1'b0; REQ1 = 1'b0;
        wait_done(t0);
        repeat (2) @(negedge CLK);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
